// File: rtl/spi_frame_arbiter_if.sv
// Request handshakes, status and SPI pins of spi_frame_arbiter, bundled as one interface.
// The slave modport is the arbiter side; master is the requester/observer side.
interface spi_frame_arbiter_if #(
  parameter int unsigned DATA_W = 16
);
  logic              req0_valid;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  logic              busy;
  logic              grant_id;
  logic              done;
  logic              SPI_NSS;
  logic              SPI_CLK;
  logic              SPI_DI;

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data,
    output req0_ready, req1_ready, busy, grant_id, done, SPI_NSS, SPI_CLK, SPI_DI
  );

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data,
    input  req0_ready, req1_ready, busy, grant_id, done, SPI_NSS, SPI_CLK, SPI_DI
  );
endinterface

// File: rtl/spi_frame_arbiter.sv
// Round-robin arbiter between two word requesters feeding one SPI mode-0 link (MSB first).
// Each grant produces one framed transfer followed by a forced NSS-high gap.
module spi_frame_arbiter #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned CLK_DIV = 2500,
  parameter int unsigned GAP_CYC = 4
) (
  input  logic                 iclk,
  input  logic                 irst,
  spi_frame_arbiter_if.slave   bus
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned GapW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int unsigned BitW = $clog2(2 * DATA_W + 1);

  typedef enum logic [1:0] {StIdle, StActive, StTail, StGap} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DivW-1:0]   div_q, div_d;
  logic [BitW-1:0]   bit_q, bit_d;
  logic [GapW-1:0]   gap_q, gap_d;
  logic              clk_q, clk_d;
  logic              ptr_q, ptr_d;
  logic              grant_q, grant_d;
  logic              sel0, sel1;
  logic              div_wrap;

  assign div_wrap = (div_q == DivW'(CLK_DIV - 1));

  always_ff @(posedge iclk) begin
    if (irst) begin
      state_q <= StIdle;
      shift_q <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      gap_q   <= '0;
      clk_q   <= 1'b0;
      ptr_q   <= 1'b0;
      grant_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      clk_q   <= clk_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
    end
  end

  // Both valid: the pointer picks; single valid always wins.
  always_comb begin
    sel0 = 1'b0;
    sel1 = 1'b0;
    if (state_q == StIdle && !irst) begin
      if (bus.req0_valid && (!bus.req1_valid || !ptr_q)) begin
        sel0 = 1'b1;
      end else if (bus.req1_valid) begin
        sel1 = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    div_d   = div_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    clk_d   = clk_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    unique case (state_q)
      StIdle: begin
        if (sel0 || sel1) begin
          shift_d = sel0 ? bus.req0_data : bus.req1_data;
          grant_d = sel1;
          ptr_d   = sel0;
          div_d   = '0;
          bit_d   = '0;
          clk_d   = 1'b0;
          state_d = StActive;
        end
      end
      StActive: begin
        if (div_wrap) begin
          div_d = '0;
          // One extra low half-period follows the last falling edge before the tail.
          if (bit_q == BitW'(2 * DATA_W)) begin
            state_d = StTail;
          end else begin
            clk_d = ~clk_q;
            bit_d = bit_q + BitW'(1);
            if (clk_q) begin
              shift_d = {shift_q[DATA_W-2:0], 1'b0};
            end
          end
        end else begin
          div_d = div_q + DivW'(1);
        end
      end
      StTail: begin
        if (div_wrap) begin
          div_d   = '0;
          gap_d   = '0;
          state_d = StGap;
        end else begin
          div_d = div_q + DivW'(1);
        end
      end
      StGap: begin
        if (gap_q == GapW'(GAP_CYC - 1)) begin
          state_d = StIdle;
        end else begin
          gap_d = gap_q + GapW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.req0_ready = sel0;
    bus.req1_ready = sel1;
    bus.busy       = (state_q != StIdle);
    bus.grant_id   = grant_q;
    bus.done       = (state_q == StGap) && (gap_q == '0);
    bus.SPI_NSS    = !((state_q == StActive) || (state_q == StTail));
    bus.SPI_CLK    = clk_q;
    bus.SPI_DI     = ((state_q == StActive) || (state_q == StTail)) ? shift_q[DATA_W-1] : 1'b0;
  end

endmodule
